// File: rtl/fp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_pkg                                                             |
// | Shared types and constants for the FP adder result packing stage.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fp_pkg;

  typedef enum logic [1:0] {
    SP_NONE    = 2'b00,
    SP_NAN     = 2'b01,
    SP_INF     = 2'b10,
    SP_INVALID = 2'b11
  } special_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef struct packed {
    logic [31:0] result;
    fp_flags_t   flags;
  } fp_beat_t;

  localparam logic [31:0] QNAN_32        = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_ALL1       = 8'hFF;
  localparam logic [7:0]  EXP_MAX_NORMAL = 8'd254;

endpackage
`default_nettype wire

// File: rtl/fp_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_pipe_reg                                                        |
// | Single valid/ready register slice carrying a payload of type T.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fp_pipe_reg #(
  parameter type T = logic
) (
  input  logic clock,
  input  logic reset,
  input  logic inValid,
  output logic inReady,
  input  T     inData,
  output logic outValid,
  input  logic outReady,
  output T     outData
);

  logic r_valid;
  T     r_data;

  // Accept when empty or when the held beat leaves on this same edge.
  assign inReady  = !r_valid || outReady;
  assign outValid = r_valid;
  assign outData  = r_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (inReady) begin
      r_valid <= inValid;
      if (inValid) begin
        r_data <= inData;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_result_pack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_result_pack                                                     |
// | Packs rounded sign/exponent/fraction into IEEE-754 single + flags. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fp_result_pack
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int XEXP_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [XEXP_W-1:0] in_exp,
  input  logic [MAN_W:0]    in_mant,
  input  logic              in_zero,
  input  logic              in_inexact,
  input  logic [1:0]        in_special,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [3:0]        out_flags,
  output logic [3:0]        sticky_flags,
  input  logic              clear_flags
);

  function automatic fp_beat_t packBeat(
    input logic              sign,
    input logic [XEXP_W-1:0] expIn,
    input logic [MAN_W:0]    mant,
    input logic              zero,
    input logic              inexact,
    input logic [1:0]        special
  );
    fp_beat_t                 w_beat;
    logic signed [XEXP_W:0]   w_expAdj;
    logic [MAN_W-1:0]         w_frac;
    w_beat   = '0;
    // One extra bit so a carry into an already-large exponent cannot wrap.
    w_expAdj = $signed({expIn[XEXP_W-1], expIn}) + $signed({{XEXP_W{1'b0}}, mant[MAN_W]});
    w_frac   = mant[MAN_W] ? '0 : mant[MAN_W-1:0];
    if (special == SP_NAN || special == SP_INVALID) begin
      w_beat.result        = QNAN_32;
      w_beat.flags.invalid = (special == SP_INVALID);
    end else if (special == SP_INF) begin
      w_beat.result = {sign, EXP_ALL1, {MAN_W{1'b0}}};
    end else if (zero) begin
      w_beat.result = {sign, {(EXP_W + MAN_W){1'b0}}};
    end else if (w_expAdj > $signed({{(XEXP_W + 1 - EXP_W){1'b0}}, EXP_MAX_NORMAL})) begin
      w_beat.result         = {sign, EXP_ALL1, {MAN_W{1'b0}}};
      w_beat.flags.overflow = 1'b1;
      w_beat.flags.inexact  = 1'b1;
    end else if (w_expAdj <= 0) begin
      w_beat.result          = {sign, {(EXP_W + MAN_W){1'b0}}};
      w_beat.flags.underflow = 1'b1;
      w_beat.flags.inexact   = 1'b1;
    end else begin
      w_beat.result        = {sign, w_expAdj[EXP_W-1:0], w_frac};
      w_beat.flags.inexact = inexact;
    end
    return w_beat;
  endfunction

  fp_beat_t   w_packed;
  fp_beat_t   w_p1Data;
  fp_beat_t   w_p2Data;
  logic       w_p1Valid;
  logic       w_p2InReady;
  logic [3:0] r_sticky;

  assign w_packed = packBeat(in_sign, in_exp, in_mant, in_zero, in_inexact, in_special);

  fp_pipe_reg #(.T(fp_beat_t)) u_p1 (
    .clock    (clock),
    .reset    (reset),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .inData   (w_packed),
    .outValid (w_p1Valid),
    .outReady (w_p2InReady),
    .outData  (w_p1Data)
  );

  fp_pipe_reg #(.T(fp_beat_t)) u_p2 (
    .clock    (clock),
    .reset    (reset),
    .inValid  (w_p1Valid),
    .inReady  (w_p2InReady),
    .inData   (w_p1Data),
    .outValid (out_valid),
    .outReady (out_ready),
    .outData  (w_p2Data)
  );

  assign out_result   = w_p2Data.result;
  assign out_flags    = w_p2Data.flags;
  assign sticky_flags = r_sticky;

  // Clear takes effect before the concurrent transfer's flags are merged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sticky <= 4'b0000;
    end else if (out_valid && out_ready) begin
      r_sticky <= (clear_flags ? 4'b0000 : r_sticky) | w_p2Data.flags;
    end else if (clear_flags) begin
      r_sticky <= 4'b0000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_result_pack.sv
`default_nettype none
// Scoreboard bench for fp_result_pack: directed beats, queued expectations,
// independent output monitor.
module tb_fp_result_pack;

  logic        clock = 0;
  logic        reset;
  logic        in_valid, in_ready, in_sign, in_zero, in_inexact;
  logic [9:0]  in_exp;
  logic [23:0] in_mant;
  logic [1:0]  in_special;
  logic        out_valid, out_ready, clear_flags;
  logic [31:0] out_result;
  logic [3:0]  out_flags, sticky_flags;

  fp_result_pack dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_zero(in_zero), .in_inexact(in_inexact), .in_special(in_special),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .clear_flags(clear_flags)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastXfer = -10;
  int run = 0;
  int maxRun = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, want);
    end
  endtask

  // Monitor: pops one expectation per output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (!reset && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got %h flags %b", out_result, out_flags);
        end else begin
          e = sb.pop_front();
          if (out_result !== e.res || out_flags !== e.fl) begin
            errors++;
            $display("FAIL %s got %h/%b expected %h/%b", e.name, out_result, out_flags, e.res, e.fl);
          end
        end
        run = (lastXfer == cyc - 1) ? run + 1 : 1;
        lastXfer = cyc;
        if (run > maxRun) maxRun = run;
      end
    end
  end

  // Call just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input string nm, input logic s, input logic [9:0] e, input logic [23:0] m,
                      input logic z, input logic nx, input logic [1:0] sp,
                      input logic [31:0] r, input logic [3:0] f);
    bit done = 0;
    int n = 0;
    exp_t x;
    in_valid = 1; in_sign = s; in_exp = e; in_mant = m;
    in_zero = z; in_inexact = nx; in_special = sp;
    while (!done) begin
      #1;
      if (in_ready) begin
        x.name = nm; x.res = r; x.fl = f;
        sb.push_back(x);
        done = 1;
      end
      @(negedge clock);
      n++;
      if (!done && n > 50) begin
        checks++; errors++;
        $display("FAIL %s accept_timeout in_ready %b expected 1", nm, in_ready);
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1; in_valid = 0; in_sign = 0; in_exp = 0; in_mant = 0;
    in_zero = 0; in_inexact = 0; in_special = 0; out_ready = 1; clear_flags = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_flags", {28'b0, out_flags}, 32'd0);
    chk("rst_sticky", {28'b0, sticky_flags}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);

    // T1 with latency check
    send("t1_one", 0, 10'd127, 24'h000000, 0, 0, 2'b00, 32'h3F80_0000, 4'b0000);
    in_valid = 0;
    #1 chk("lat_cycle1_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clock);
    #1 chk("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clock);

    // T2-T4 and boundaries
    send("t2_carry", 0, 10'd127, 24'h800000, 0, 0, 2'b00, 32'h4000_0000, 4'b0000);
    send("t2_carry_of", 0, 10'd254, 24'h800000, 0, 0, 2'b00, 32'h7F80_0000, 4'b0101);
    send("t3_exp255", 0, 10'd255, 24'h000000, 0, 0, 2'b00, 32'h7F80_0000, 4'b0101);
    send("t3_uf", 1, 10'd0, 24'h012345, 0, 0, 2'b00, 32'h8000_0000, 4'b0011);
    send("t4_nan", 0, 10'd5, 24'h123456, 0, 0, 2'b01, 32'h7FC0_0000, 4'b0000);
    send("t4_invalid", 1, 10'd5, 24'h123456, 0, 1, 2'b11, 32'h7FC0_0000, 4'b1000);
    send("t4_ninf", 1, 10'd5, 24'h000000, 0, 1, 2'b10, 32'hFF80_0000, 4'b0000);
    send("neg_zero", 1, 10'd300, 24'h7FFFFF, 1, 1, 2'b00, 32'h8000_0000, 4'b0000);
    send("normal_nx", 1, 10'd130, 24'h400000, 0, 1, 2'b00, 32'hC140_0000, 4'b0001);
    send("neg_exp_uf", 0, 10'h3FB, 24'h7FFFFF, 0, 0, 2'b00, 32'h0000_0000, 4'b0011);
    send("exp0_carry", 0, 10'd0, 24'h800000, 0, 1, 2'b00, 32'h0080_0000, 4'b0001);
    send("max_normal", 0, 10'd254, 24'h7FFFFF, 0, 0, 2'b00, 32'h7F7F_FFFF, 4'b0000);
    idle(4);

    // T5 backpressure
    out_ready = 0;
    send("t5_a", 0, 10'd128, 24'h000000, 0, 0, 2'b00, 32'h4000_0000, 4'b0000);
    send("t5_b", 0, 10'd129, 24'h000000, 0, 0, 2'b00, 32'h4080_0000, 4'b0000);
    in_valid = 1; in_exp = 10'd130; in_mant = 24'h0; in_special = 0; in_zero = 0;
    repeat (4) begin
      #1;
      chk("t5_in_ready_low", {31'b0, in_ready}, 32'd0);
      chk("t5_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("t5_hold_result", out_result, 32'h4000_0000);
      @(negedge clock);
    end
    out_ready = 1;
    send("t5_c", 0, 10'd130, 24'h000000, 0, 0, 2'b00, 32'h4100_0000, 4'b0000);
    idle(4);

    maxRun = 0;
    send("t5_s0", 0, 10'd127, 24'h000001, 0, 0, 2'b00, 32'h3F80_0001, 4'b0000);
    send("t5_s1", 0, 10'd127, 24'h000002, 0, 0, 2'b00, 32'h3F80_0002, 4'b0000);
    send("t5_s2", 0, 10'd127, 24'h000003, 0, 0, 2'b00, 32'h3F80_0003, 4'b0000);
    send("t5_s3", 0, 10'd127, 24'h000004, 0, 0, 2'b00, 32'h3F80_0004, 4'b0000);
    idle(5);
    chk("t5_throughput_run", maxRun, 32'd4);

    // T6 sticky
    clear_flags = 1;
    @(negedge clock);
    clear_flags = 0;
    #1 chk("t6_cleared", {28'b0, sticky_flags}, 32'd0);
    send("t6_of", 0, 10'd255, 24'h000000, 0, 0, 2'b00, 32'h7F80_0000, 4'b0101);
    send("t6_nx", 0, 10'd127, 24'h000000, 0, 1, 2'b00, 32'h3F80_0000, 4'b0001);
    idle(4);
    #1 chk("t6_sticky_of_nx", {28'b0, sticky_flags}, 32'b0101);
    out_ready = 0;
    @(negedge clock);
    send("t6_uf", 1, 10'd0, 24'h000010, 0, 0, 2'b00, 32'h8000_0000, 4'b0011);
    idle(2);
    clear_flags = 1; out_ready = 1;
    @(negedge clock);
    clear_flags = 0;
    #3 chk("t6_clear_with_uf", {28'b0, sticky_flags}, 32'b0011);
    @(negedge clock);

    // Reset with two beats in flight
    out_ready = 0;
    send("t6_drop0", 0, 10'd127, 24'h0, 0, 0, 2'b00, 32'h3F80_0000, 4'b0000);
    send("t6_drop1", 0, 10'd255, 24'h0, 0, 0, 2'b00, 32'h7F80_0000, 4'b0101);
    in_valid = 0;
    reset = 1;
    repeat (2) @(negedge clock);
    sb.delete();
    reset = 0;
    #1;
    chk("t6_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_sticky", {28'b0, sticky_flags}, 32'd0);
    chk("t6_rst_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1;
    @(negedge clock);
    idle(6);
    chk("final_queue_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time %0t limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
